// File: rtl/scalar_alu_pipe.sv
// Pipelined scalar ALU with a valid/ready handshake, a sticky condition-flag register and an iterative shift-add multiplier.
// Optional macro SCALAR_ALU_SAT_EN enables signed saturation of ADD/SUB and drives the 'of' output.
module scalar_alu_pipe #(
    parameter int WIDTH    = 36,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             of,
    output logic             busy,
    output logic             nz,
    output logic             ez,
    output logic             lz,
    output logic             gz,
    output logic             le,
    output logic             ge
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] mul_a, mul_b, mul_acc, mul_sum;
    logic [CNT_W-1:0] mul_cnt;
    logic             mul_upd;
    logic [WIDTH-1:0] alu_res, wr_res;
    logic             accept, alu_wr, mul_start, mul_wr, wr_upd;
    logic [5:0]       flags;

    function automatic logic [5:0] flags_of(input logic [WIDTH-1:0] res);
        logic is_zero, is_neg;
        is_zero = (res == '0);
        is_neg  = res[WIDTH-1];
        return {!is_zero, is_zero, is_neg, !is_neg && !is_zero, is_neg || is_zero, !is_neg};
    endfunction

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op[2:0] == OP_MUL);
    assign alu_wr    = accept && (op[2:0] != OP_MUL);
    assign mul_wr    = (state == MUL) && (mul_cnt == LAST);
    assign busy      = (state == MUL);
    assign wr_res    = mul_wr ? mul_sum : alu_res;
    assign wr_upd    = mul_wr ? mul_upd : op[3];
    assign {nz, ez, lz, gz, le, ge} = flags;

`ifdef SCALAR_ALU_SAT_EN
    logic [WIDTH:0] add_ext, sub_ext;
    logic           alu_of, of_reg;

    assign add_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign sub_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign of      = of_reg;

    // The extra sign bit disagrees with the result MSB exactly when the signed result left the range.
    function automatic logic [WIDTH:0] clamp(input logic [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1])
            return {1'b1, s[WIDTH], {(WIDTH-1){!s[WIDTH]}}};
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            of_reg <= 1'b0;
        else if (mul_wr)
            of_reg <= 1'b0;
        else if (alu_wr)
            of_reg <= alu_of;
    end
`else
    assign of = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
`ifdef SCALAR_ALU_SAT_EN
        alu_of  = 1'b0;
`endif
        case (op[2:0])
            OP_ADD: begin
`ifdef SCALAR_ALU_SAT_EN
                {alu_of, alu_res} = clamp(add_ext);
`else
                alu_res = a + b;
`endif
            end
            OP_SUB: begin
`ifdef SCALAR_ALU_SAT_EN
                {alu_of, alu_res} = clamp(sub_ext);
`else
                alu_res = a - b;
`endif
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = (b >= WIDTH_V) ? '0 : (a << b);
            OP_SHR:  alu_res = (b >= WIDTH_V) ? '0 : (a >> b);
            default: alu_res = '0;
        endcase
    end

    // One multiplier slice per cycle: add the shifted multiplicand for each set bit of the low MUL_STEP bits.
    always_comb begin
        mul_sum = mul_acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mul_b[i])
                mul_sum = mul_sum + (mul_a << i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_wr)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
            mul_upd <= 1'b0;
        end else if (mul_start) begin
            mul_a   <= a;
            mul_b   <= b;
            mul_acc <= '0;
            mul_cnt <= '0;
            mul_upd <= op[3];
        end else if (state == MUL) begin
            mul_acc <= mul_sum;
            mul_a   <= mul_a << MUL_STEP;
            mul_b   <= mul_b >> MUL_STEP;
            mul_cnt <= mul_cnt + CNT_W'(1);
        end
    end

    // A new result takes priority over draining, so drain plus accept keeps out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            flags     <= '0;
        end else if (alu_wr || mul_wr) begin
            out       <= wr_res;
            out_valid <= 1'b1;
            if (wr_upd)
                flags <= flags_of(wr_res);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scalar_alu_pipe.sv
// Self-checking bench for scalar_alu_pipe: directed cases plus randomized ops against a behavioural model.
module tb_scalar_alu_pipe;

    localparam int W = 36;
    localparam int MUL_LAT = 36;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         of, busy, nz, ez, lz, gz, le, ge;

    int           errors = 0;
    int           checks = 0;
    logic [5:0]   exp_flags;

    scalar_alu_pipe #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .of(of), .busy(busy), .nz(nz), .ez(ez), .lz(lz), .gz(gz), .le(le), .ge(ge)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Flags from the signed ordering of the result, in port order nz,ez,lz,gz,le,ge.
    function automatic logic [5:0] model_flags(input logic [W-1:0] res);
        longint s;
        s = longint'($signed(res));
        return {s != 0, s == 0, s < 0, s > 0, s <= 0, s >= 0};
    endfunction

    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] res, output logic ofl);
        longint      sx, sy, s;
        longint      maxv, minv;
        logic [63:0] s_bits;
        logic [2*W-1:0] prod;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        ofl  = 1'b0;
        res  = '0;
        case (o[2:0])
            3'd0, 3'd1: begin
                s = (o[2:0] == 3'd0) ? sx + sy : sx - sy;
`ifdef SCALAR_ALU_SAT_EN
                if (s > maxv) begin s = maxv; ofl = 1'b1; end
                else if (s < minv) begin s = minv; ofl = 1'b1; end
`endif
                s_bits = s;
                res = s_bits[W-1:0];
            end
            3'd2: begin
                prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                res  = prod[W-1:0];
            end
            3'd3: res = x & y;
            3'd4: res = x | y;
            3'd5: res = x ^ y;
            3'd6: res = (y >= 64'(W)) ? '0 : x << y;
            3'd7: res = (y >= 64'(W)) ? '0 : x >> y;
            default: res = '0;
        endcase
    endfunction

    // Issue one op, wait for its result and compare result, overflow and flags with the model.
    task automatic apply_stimulus(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         eo;
        int           n;
        int           ready_seen;
        model(o, x, y, er, eo);
        if (o[3])
            exp_flags = model_flags(er);
        in_valid = 1'b1;
        op = o; a = x; b = y;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check_output({tag, "_accept_timeout"}, 64'(n < 100), 64'(1));
        step();
        if (o[2:0] == 3'd2) begin
            op = 4'b0000; a = 36'd1; b = 36'd1;
            n = 0;
            ready_seen = 0;
            while (!out_valid && n < 200) begin
                if (in_ready || !busy)
                    ready_seen++;
                step();
                n++;
            end
            in_valid = 1'b0;
            check_output({tag, "_mul_latency"}, 64'(n), 64'(MUL_LAT));
            check_output({tag, "_busy_gate"}, 64'(ready_seen), 64'(0));
            check_output({tag, "_busy_done"}, 64'(busy), 64'(0));
        end
        in_valid = 1'b0;
        check_output({tag, "_valid"}, 64'(out_valid), 64'(1));
        check_output({tag, "_out"}, 64'(out), 64'(er));
        check_output({tag, "_of"}, 64'(of), 64'(eo));
        check_output({tag, "_flags"}, 64'({nz, ez, lz, gz, le, ge}), 64'(exp_flags));
    endtask

    initial begin
        logic [63:0]  r64;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        exp_flags = '0;
        repeat (2) step();
        check_output("rst_valid", 64'(out_valid), 64'(0));
        check_output("rst_out", 64'(out), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_flags", 64'({nz, ez, lz, gz, le, ge}), 64'(0));
        check_output("rst_of", 64'(of), 64'(0));
        rst_n = 1'b1;
        step();
        check_output("rst_ready", 64'(in_ready), 64'(1));

        apply_stimulus("add", 4'b0000, 36'd5, 36'd7);
        check_output("add_const", 64'(out), 64'd12);
        step();
        check_output("add_drain", 64'(out_valid), 64'(0));

        apply_stimulus("cmp", 4'b1001, 36'd3, 36'd9);
        check_output("cmp_const", 64'(out), 64'h0_0000_000F_FFFF_FFFA);
        check_output("cmp_flags_const", 64'({nz, ez, lz, gz, le, ge}), 64'(6'b101010));
        apply_stimulus("hold_flags", 4'b0000, 36'd1, 36'd1);

        apply_stimulus("mul", 4'b0010, 36'd1000, 36'd3000);
        check_output("mul_const", 64'(out), 64'd3000000);

        step();
        out_ready = 1'b0;
        apply_stimulus("bp_first", 4'b0000, 36'd10, 36'd20);
        in_valid = 1'b1; op = 4'b0000; a = 36'd1; b = 36'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("bp_ready_low", 64'(in_ready), 64'(0));
            check_output("bp_out_stable", 64'(out), 64'd30);
        end
        out_ready = 1'b1;
        #1;
        check_output("bp_ready_high", 64'(in_ready), 64'(1));
        step();
        check_output("b2b_first", 64'(out), 64'd3);
        check_output("b2b_valid", 64'(out_valid), 64'(1));
        a = 36'd4; b = 36'd4;
        step();
        check_output("b2b_second", 64'(out), 64'd8);
        in_valid = 1'b0;
        step();
        check_output("b2b_drain", 64'(out_valid), 64'(0));

        apply_stimulus("shl35", 4'b0110, 36'd1, 36'd35);
        check_output("shl35_const", 64'(out), 64'h8_0000_0000);
        apply_stimulus("shr36", 4'b1111, 36'hF_FFFF_FFFF, 36'd36);
        check_output("shr36_const", 64'(out), 64'(0));
        apply_stimulus("shl_big", 4'b0110, 36'd1, 36'h8_0000_0001);

        for (int i = 0; i < 40; i++) begin
            r64 = {$urandom(), $urandom()};
            ra  = r64[W-1:0];
            r64 = {$urandom(), $urandom()};
            rb  = r64[W-1:0];
            ro  = 4'($urandom_range(0, 15));
            if (ro[2:1] == 2'b11)
                rb = 36'($urandom_range(0, 40));
            apply_stimulus("rand", ro, ra, rb);
        end

        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_flags = '0;
        step();
        in_valid = 1'b1; op = 4'b1010; a = 36'd5; b = 36'd7;
        step();
        in_valid = 1'b0;
        check_output("abort_busy_before", 64'(busy), 64'(1));
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check_output("abort_valid", 64'(out_valid), 64'(0));
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_flags", 64'({nz, ez, lz, gz, le, ge}), 64'(exp_flags));
        step();
        rst_n = 1'b1;
        repeat (40) step();
        check_output("abort_no_result", 64'(out_valid), 64'(0));
        check_output("abort_flags_late", 64'({nz, ez, lz, gz, le, ge}), 64'(exp_flags));

        apply_stimulus("sat_add", 4'b0000, 36'h7_FFFF_FFFF, 36'd1);
`ifdef SCALAR_ALU_SAT_EN
        check_output("sat_add_const", 64'(out), 64'h7_FFFF_FFFF);
        check_output("sat_add_of", 64'(of), 64'(1));
`else
        check_output("sat_add_const", 64'(out), 64'h8_0000_0000);
        check_output("sat_add_of", 64'(of), 64'(0));
`endif
        apply_stimulus("sat_sub", 4'b1001, 36'h8_0000_0000, 36'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
